// File: rtl/flag_run_monitor.sv
// Watches the upstream sequencer flag: arms on en, then needs HOLD consecutive
// high samples before a TIMEOUT window of low samples runs out.
module flag_run_monitor #(
  parameter int HOLD    = 2,
  parameter int TIMEOUT = 8,
  parameter int CW      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          flag,
  input  logic          clr,
  output logic [2:0]    state,
  output logic          hit,
  output logic          done,
  output logic          tmo,
  output logic [CW-1:0] rise_cnt,
  output logic [CW-1:0] run_len
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT - 1);
  localparam logic [CW-1:0] HMAX = CW'(HOLD - 1);
  localparam logic [CW-1:0] HLEN = CW'(HOLD);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WAIT    = 3'd1,
    ST_HOLD    = 3'd2,
    ST_DONE    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t        cur;
  logic          prev_flag;
  logic [TW-1:0] timer;
  logic          rise;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  assign rise  = flag & ~prev_flag;
  assign state = cur;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur       <= ST_IDLE;
      hit       <= 1'b0;
      done      <= 1'b0;
      tmo       <= 1'b0;
      rise_cnt  <= '0;
      run_len   <= '0;
      prev_flag <= 1'b0;
      timer     <= '0;
    end else begin
      prev_flag <= flag;
      hit       <= 1'b0;
      if (clr) begin
        cur      <= ST_IDLE;
        done     <= 1'b0;
        tmo      <= 1'b0;
        rise_cnt <= '0;
        run_len  <= '0;
        timer    <= '0;
      end else begin
        if (rise && (cur != ST_IDLE))
          rise_cnt <= sat_inc(rise_cnt);
        case (cur)
          ST_IDLE: begin
            if (en) begin
              cur   <= ST_WAIT;
              timer <= '0;
            end
          end
          ST_WAIT: begin
            // A high flag wins over an expiring timeout window.
            if (flag) begin
              run_len <= CW'(1);
              if (HOLD == 1) begin
                cur  <= ST_DONE;
                hit  <= 1'b1;
                done <= 1'b1;
              end else begin
                cur <= ST_HOLD;
              end
            end else if (timer == TMAX) begin
              cur <= ST_TIMEOUT;
              tmo <= 1'b1;
            end else begin
              timer <= timer + 1'b1;
            end
          end
          ST_HOLD: begin
            if (flag) begin
              if (run_len == HMAX) begin
                cur     <= ST_DONE;
                run_len <= HLEN;
                hit     <= 1'b1;
                done    <= 1'b1;
              end else begin
                run_len <= sat_inc(run_len);
              end
            end else begin
              cur     <= ST_WAIT;
              run_len <= '0;
              timer   <= '0;
            end
          end
          ST_DONE, ST_TIMEOUT: begin
          end
          default: begin
            cur     <= ST_IDLE;
            run_len <= '0;
            timer   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_flag_run_monitor.sv
// Directed bench for flag_run_monitor: default instance plus a CW=2 instance
// sharing the same stimulus for the saturation case.
module tb_flag_run_monitor;

  logic       clk = 1'b0;
  logic       reset, en, flag, clr;
  logic [2:0] state, state_s;
  logic       hit, done, tmo, hit_s, done_s, tmo_s;
  logic [3:0] rise_cnt, run_len;
  logic [1:0] rise_cnt_s, run_len_s;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  flag_run_monitor dut (
    .clk(clk), .reset(reset), .en(en), .flag(flag), .clr(clr),
    .state(state), .hit(hit), .done(done), .tmo(tmo),
    .rise_cnt(rise_cnt), .run_len(run_len)
  );

  flag_run_monitor #(.HOLD(2), .TIMEOUT(8), .CW(2)) dut_sat (
    .clk(clk), .reset(reset), .en(en), .flag(flag), .clr(clr),
    .state(state_s), .hit(hit_s), .done(done_s), .tmo(tmo_s),
    .rise_cnt(rise_cnt_s), .run_len(run_len_s)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1; flag = 1'b0; en = 1'b0;
    tick();
    clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; en = 1'b0; flag = 1'b0; clr = 1'b0;
    #3;
    check("rst_state", state, 0);
    check("rst_hit", hit, 0);
    check("rst_done", done, 0);
    check("rst_tmo", tmo, 0);
    check("rst_rise", rise_cnt, 0);
    check("rst_run", run_len, 0);
    tick();
    reset = 1'b0;

    // Timeout: 8 consecutive low samples in WAIT
    en = 1'b1; tick(); en = 1'b0;
    check("t2_wait", state, 1);
    repeat (7) tick();
    check("t2_wait7", state, 1);
    check("t2_tmo7", tmo, 0);
    tick();
    check("t2_state", state, 4);
    check("t2_tmo", tmo, 1);
    check("t2_hit", hit, 0);
    check("t2_done", done, 0);
    flag = 1'b1; tick();
    check("t2_stuck", state, 4);
    check("t2_nodone", done, 0);
    do_clr();
    check("t2_clr_state", state, 0);
    check("t2_clr_tmo", tmo, 0);
    check("t2_clr_rise", rise_cnt, 0);

    // Flag on the 8th WAIT sample beats the timeout
    en = 1'b1; tick(); en = 1'b0;
    repeat (7) tick();
    flag = 1'b1; tick();
    check("t5_state", state, 2);
    check("t5_tmo", tmo, 0);
    check("t5_run", run_len, 1);
    do_clr();

    // Clean run
    en = 1'b1; tick(); en = 1'b0;
    repeat (3) tick();
    check("t3_wait", state, 1);
    flag = 1'b1; tick();
    check("t3_hold", state, 2);
    check("t3_hit0", hit, 0);
    check("t3_run1", run_len, 1);
    tick();
    check("t3_done_state", state, 3);
    check("t3_hit", hit, 1);
    check("t3_done", done, 1);
    check("t3_run2", run_len, 2);
    check("t3_rise", rise_cnt, 1);
    flag = 1'b0; tick();
    check("t3_hit_drop", hit, 0);
    check("t3_done_stick", done, 1);
    check("t3_state_hold", state, 3);
    do_clr();

    // Broken run 1,0,1,1
    en = 1'b1; tick(); en = 1'b0;
    flag = 1'b1; tick(); check("t4_s1", state, 2);
    flag = 1'b0; tick(); check("t4_s2", state, 1);
    check("t4_run0", run_len, 0);
    flag = 1'b1; tick(); check("t4_s3", state, 2);
    tick();
    check("t4_s4", state, 3);
    check("t4_rise", rise_cnt, 2);
    check("t4_done", done, 1);
    do_clr();

    // Asynchronous reset in HOLD, between edges
    en = 1'b1; tick(); en = 1'b0;
    flag = 1'b1; tick();
    check("t1_pre_state", state, 2);
    check("t1_pre_run", run_len, 1);
    check("t1_pre_rise", rise_cnt, 1);
    #2 reset = 1'b1;
    #1;
    check("t1_state", state, 0);
    check("t1_run", run_len, 0);
    check("t1_rise", rise_cnt, 0);
    #1 reset = 1'b0;
    flag = 1'b0; tick();
    check("t1_idle", state, 0);

    // Saturation with CW=2, then clr beats en
    en = 1'b1; tick(); en = 1'b0;
    for (int i = 0; i < 9; i++) begin
      flag = (i % 2 == 0);
      tick();
    end
    check("t6_sat_rise", rise_cnt_s, 3);
    check("t6_wide_rise", rise_cnt, 5);
    check("t6_state", state, 2);
    clr = 1'b1; en = 1'b1; flag = 1'b0; tick();
    clr = 1'b0; en = 1'b0;
    check("t6_clr_state", state, 0);
    check("t6_clr_hit", hit, 0);
    check("t6_clr_done", done, 0);
    check("t6_clr_tmo", tmo, 0);
    check("t6_clr_rise", rise_cnt, 0);
    check("t6_clr_run", run_len, 0);
    check("t6_clr_rise_s", rise_cnt_s, 0);
    tick();
    check("t6_idle_next", state, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
